// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency prediction for IF,
// update and misprediction/recovery reporting for branches resolved in ID, plus statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_recover_pc,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_mispredicts
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [31:0]     r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic [31:0]     r_stat_branches;
  logic [31:0]     r_stat_mispredicts;

  logic [IDX-1:0]  w_if_idx;
  logic [TAGW-1:0] w_if_tag;
  logic            w_if_hit;
  logic [IDX-1:0]  w_upd_idx;
  logic [TAGW-1:0] w_upd_tag;
  logic            w_upd_hit;
  logic            w_mispredict;
  logic            w_unused;

  assign w_if_idx  = i_if_pc[IDX+1:2];
  assign w_if_tag  = i_if_pc[31:IDX+2];
  assign w_upd_idx = i_upd_pc[IDX+1:2];
  assign w_upd_tag = i_upd_pc[31:IDX+2];
  assign w_unused  = ^{i_if_pc[1:0], i_upd_pc[1:0]};

  assign w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Prediction reads pre-update contents; there is no write bypass.
  assign o_pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign o_pred_target = o_pred_taken ? r_target[w_if_idx] : 32'd0;

  assign w_mispredict = i_upd_valid &&
                        ((i_upd_taken != i_upd_pred_taken) ||
                         (i_upd_taken && (i_upd_pred_target != i_upd_target)));
  assign o_mispredict = w_mispredict;
  assign o_recover_pc = !i_upd_valid ? 32'd0 :
                        (i_upd_taken ? i_upd_target : i_upd_pc + 32'd4);

  // BTB update: train on hits, allocate only on taken misses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        if (i_upd_taken) begin
          if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
          r_target[w_upd_idx] <= i_upd_target;
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else begin
      if (i_upd_valid && (r_stat_branches != 32'hFFFF_FFFF))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign o_stat_branches    = r_stat_branches;
  assign o_stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan steps, then random
// traffic against a table-of-entries reference model.
module tb_branch_predictor;

  localparam int unsigned ENT  = 16;
  localparam int unsigned IDXB = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per BTB slot, counter kept as a plain integer 0..3.
  bit          m_valid [ENT];
  longint      m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  longint      m_branches;
  longint      m_misp;

  branch_predictor #(.ENTRIES(ENT)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_if_pc            (if_pc),
    .o_pred_taken       (pred_taken),
    .o_pred_target      (pred_target),
    .i_upd_valid        (upd_valid),
    .i_upd_pc           (upd_pc),
    .i_upd_taken        (upd_taken),
    .i_upd_target       (upd_target),
    .i_upd_pred_taken   (upd_pred_taken),
    .i_upd_pred_target  (upd_pred_target),
    .o_mispredict       (mispredict),
    .o_recover_pc       (recover_pc),
    .o_stat_branches    (stat_branches),
    .o_stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic longint tagof(input logic [31:0] pc);
    return longint'(pc) / (longint'(4) * ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_misp = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive after negedge, check combinational outputs, then the edge, then stats.
  task automatic step(input logic [31:0] ipc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit upt,
                      input logic [31:0] uptgt);
    bit          e_misp;
    logic [31:0] e_rec;
    int          s;
    if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    #1;
    e_misp = uv && ((ut != upt) || (ut && (uptgt != utgt)));
    e_rec  = !uv ? 32'd0 : (ut ? utgt : 32'(longint'(upc) + 4));
    chk("pred_taken",  {31'd0, pred_taken}, {31'd0, m_pred(ipc)});
    chk("pred_target", pred_target, m_pred(ipc) ? m_tgt[slot(ipc)] : 32'd0);
    chk("mispredict",  {31'd0, mispredict}, {31'd0, e_misp});
    chk("recover_pc",  recover_pc, e_rec);
    @(posedge clk);
    if (uv) begin
      s = slot(upc);
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = utgt;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (ut) begin
        m_valid[s] = 1'b1; m_tag[s] = tagof(upc); m_tgt[s] = utgt; m_ctr[s] = 2;
      end
      if (m_branches < 64'hFFFF_FFFF) m_branches++;
      if (e_misp && m_misp < 64'hFFFF_FFFF) m_misp++;
    end
    #1;
    chk("stat_branches",    stat_branches,    32'(m_branches));
    chk("stat_mispredicts", stat_mispredicts, 32'(m_misp));
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(ipc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0050;
  localparam logic [31:0] TA = 32'h0040_0100;

  initial begin
    logic [31:0] rpc, rtgt;
    bit          rt, rpt;
    rst_n = 1'b0;
    if_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle(PA);

    // Allocate, with the same-cycle read seeing pre-update contents.
    step(PA, 1'b1, PA, 1'b1, TA, 1'b0, 32'd0);
    chk("alloc_pred_next", 32'(m_pred(PA)), 32'd1);
    idle(PA);
    chk("alloc_target_dut", pred_target, TA);

    // Counter saturation up, then walk down through the hysteresis and floor.
    repeat (3) step(PA, 1'b1, PA, 1'b1, TA, 1'b1, TA);
    step(PA, 1'b1, PA, 1'b0, 32'd0, 1'b1, TA);
    idle(PA);
    step(PA, 1'b1, PA, 1'b0, 32'd0, 1'b1, TA);
    idle(PA);
    repeat (2) step(PA, 1'b1, PA, 1'b0, 32'd0, 1'b0, 32'd0);
    step(PA, 1'b1, PA, 1'b1, TA, 1'b0, 32'd0);
    idle(PA);
    chk("floor_then_taken", {31'd0, pred_taken}, 32'd0);
    repeat (2) step(PA, 1'b1, PA, 1'b1, TA, 1'b0, TA);
    idle(PA);

    // Aliasing: taken evicts, not-taken leaves the entry alone.
    step(PA, 1'b1, PB, 1'b1, 32'h0040_0200, 1'b0, 32'd0);
    idle(PA);
    idle(PB);
    chk("alias_pb_taken", {31'd0, pred_taken}, 32'd1);
    step(PB, 1'b1, PA, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(PB);
    chk("alias_nt_keeps", pred_target, 32'h0040_0200);

    // Target mispredict and recovery wrap.
    step(32'h0, 1'b1, 32'h0000_1000, 1'b1, 32'h200, 1'b1, 32'h100);
    step(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 32'h100);

    // Asynchronous reset mid-run with entries populated.
    #2 rst_n = 1'b0;
    m_reset();
    if_pc = PB; upd_valid = 1'b0;
    #1;
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_stat_br",    stat_branches, 32'd0);
    chk("rst_stat_misp",  stat_mispredicts, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(PA);
    idle(PB);

    // Random traffic over a small PC window to force hits and aliasing.
    for (int n = 0; n < 400; n++) begin
      rpc  = 32'h0040_0000 + 32'($urandom_range(0, 47)) * 4;
      rtgt = 32'h0050_0000 + 32'($urandom_range(0, 7)) * 4;
      rt   = 1'($urandom_range(0, 1));
      rpt  = ($urandom_range(0, 3) == 0) ? ~m_pred(rpc) : m_pred(rpc);
      step(32'h0040_0000 + 32'($urandom_range(0, 47)) * 4,
           1'($urandom_range(0, 4) != 0), rpc, rt, rtgt, rpt,
           ($urandom_range(0, 3) == 0) ? rtgt + 32'd4 : rtgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
